// File: rtl/sub1_pkg.sv
// rtl/sub1_pkg.sv - FSM state type, requester tag type and default parameters for the sub1 arbiter
package sub1_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int DW_DEF      = 32;
  localparam int TIMEOUT_DEF = 255;
  localparam int IDW_DEF     = $clog2(NREQ_DEF);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_t;

  typedef logic [IDW_DEF-1:0] req_id_t;

endpackage

// File: rtl/sub1_arb_if.sv
// rtl/sub1_arb_if.sv - requester-side and sub1-side signals of the sub1 arbiter
interface sub1_arb_if
  import sub1_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) ();

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               s_valid;
  logic               s_ready;
  logic [DW-1:0]      s_data;
  logic [IDW-1:0]     s_id;
  logic               s_rsp_valid;
  logic [IDW-1:0]     s_rsp_id;
  logic [DW-1:0]      s_rsp_data;
  logic               busy;
  logic               timeout_err;

  // arbiter view
  modport slave (
    input  req_valid, req_data, s_ready, s_rsp_valid, s_rsp_id, s_rsp_data,
    output req_ready, rsp_valid, rsp_data, s_valid, s_data, s_id, busy, timeout_err
  );

  // requesters plus sub1 view
  modport master (
    output req_valid, req_data, s_ready, s_rsp_valid, s_rsp_id, s_rsp_data,
    input  req_ready, rsp_valid, rsp_data, s_valid, s_data, s_id, busy, timeout_err
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin pick: first asserted request scanning upward from ptr, modulo NREQ
module rr_pick
  import sub1_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  grant,
  output logic            any_req
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      // one extra bit keeps ptr+i from wrapping before the modulo fold
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ))
        sum = sum - (IDW+1)'(NREQ);
      cand = sum[IDW-1:0];
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        grant   = cand;
      end
    end
  end

endmodule

// File: rtl/sub1_arb.sv
// rtl/sub1_arb.sv - round-robin arbiter sharing one sub1 instance among NREQ requesters,
// one transaction outstanding, with response-id matching and a response timeout.
module sub1_arb
  import sub1_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic       clk,
  input logic       rst,
  sub1_arb_if.slave bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  arb_state_t     state, state_nxt;
  logic [IDW-1:0] grant_q, rr_ptr, pick, ptr_nxt;
  logic           any_req;
  logic [DW-1:0]  data_q, pick_data, rsp_data_q;
  logic [CW-1:0]  cnt;
  logic [NREQ-1:0] rsp_valid_q;
  logic           timeout_q;
  logic           accept, issue_done, rsp_hit, tmo_hit;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick == IDW'(i))
        pick_data = bus.req_data[i*DW +: DW];
  end

  assign ptr_nxt = (pick == IDW'(NREQ - 1)) ? '0 : pick + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    issue_done    = 1'b0;
    rsp_hit       = 1'b0;
    tmo_hit       = 1'b0;
    bus.req_ready = '0;
    bus.s_valid   = 1'b0;
    bus.busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
          // a grant made while reset is held would be discarded, so do not advertise it
          if (!rst)
            bus.req_ready[pick] = 1'b1;
        end
      end
      ISSUE: begin
        bus.s_valid = 1'b1;
        if (bus.s_ready) begin
          issue_done = 1'b1;
          state_nxt  = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // a matching response beats a timeout landing in the same cycle
        if (bus.s_rsp_valid && bus.s_rsp_id == grant_q) begin
          rsp_hit   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      grant_q     <= '0;
      data_q      <= '0;
      cnt         <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      timeout_q   <= 1'b0;
      if (accept) begin
        grant_q <= pick;
        data_q  <= pick_data;
        rr_ptr  <= ptr_nxt;
      end
      if (issue_done)
        cnt <= '0;
      else if (state == WAIT_RSP)
        cnt <= cnt + CW'(1);
      if (rsp_hit) begin
        rsp_data_q  <= bus.s_rsp_data;
        rsp_valid_q <= NREQ'(1) << grant_q;
      end
      if (tmo_hit)
        timeout_q <= 1'b1;
    end
  end

  assign bus.s_data      = data_q;
  assign bus.s_id        = grant_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_sub1_arb.sv
// tb/tb_sub1_arb.sv - directed plus randomized bench for sub1_arb; the bench plays requesters and sub1
// and predicts grants, payloads, responses and timeouts from a round-robin reference model.
module tb_sub1_arb;
  import sub1_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int TMO  = 8;
  localparam int IDW  = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   exp_ptr = 0;

  always #5 clk = ~clk;

  sub1_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

  sub1_arb #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_model(input logic [NREQ-1:0] m, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (m[(ptr + k) % NREQ])
        return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ*DW-1:0] rand_payload();
    logic [NREQ*DW-1:0] p;
    for (int i = 0; i < NREQ; i++)
      p[i*DW +: DW] = $urandom;
    return p;
  endfunction

  // mode 0: response on wait cycle rsp_at; 1: no response (timeout); 2: response on the timeout cycle;
  // 3: reset during the wait followed by a late response
  task automatic txn(input logic [NREQ-1:0] mask, input int bp, input int rsp_at, input int mode,
                     input bit noise);
    int                 g;
    logic [DW-1:0]      d;
    logic [DW-1:0]      rsp_exp;
    logic [NREQ*DW-1:0] pay;
    req_id_t            gid;
    bit                 matching;
    int                 fire;

    pay = rand_payload();
    rsp_exp = '0;
    @(negedge clk);
    bus.req_valid   = mask;
    bus.req_data    = pay;
    bus.s_ready     = 1'b0;
    bus.s_rsp_valid = 1'b0;
    #1;
    g   = rr_model(mask, exp_ptr);
    gid = req_id_t'(g);
    d   = pay[g*DW +: DW];
    chk("idle_busy", 32'(bus.busy), 0);
    chk("grant", 32'(bus.req_ready), 1 << g);
    exp_ptr = (g + 1) % NREQ;

    for (int k = 0; k <= bp; k++) begin
      @(negedge clk);
      bus.req_valid = NREQ'($urandom);
      bus.req_data  = rand_payload();
      bus.s_ready   = (k == bp);
      #1;
      chk("s_valid", 32'(bus.s_valid), 1);
      chk("s_data", bus.s_data, d);
      chk("s_id", 32'(bus.s_id), g);
      chk("issue_ready", 32'(bus.req_ready), 0);
      chk("issue_busy", 32'(bus.busy), 1);
    end

    fire = (mode == 0) ? rsp_at : TMO;
    for (int w = 1; w <= TMO; w++) begin
      @(negedge clk);
      bus.s_ready = 1'(($urandom));
      if (mode == 3 && w == 3) begin
        rst             = 1'b1;
        bus.s_rsp_valid = 1'b0;
        break;
      end
      matching = (w == fire) && (mode == 0 || mode == 2);
      if (matching) begin
        rsp_exp          = $urandom;
        bus.s_rsp_valid  = 1'b1;
        bus.s_rsp_id     = gid;
        bus.s_rsp_data   = rsp_exp;
      end else if (noise && (w % 2 == 0)) begin
        bus.s_rsp_valid  = 1'b1;
        bus.s_rsp_id     = IDW'((g + 1 + int'($urandom_range(0, NREQ - 2))) % NREQ);
        bus.s_rsp_data   = $urandom;
      end else begin
        bus.s_rsp_valid  = 1'b0;
      end
      #1;
      chk("wait_s_valid", 32'(bus.s_valid), 0);
      chk("wait_busy", 32'(bus.busy), 1);
      chk("wait_ready", 32'(bus.req_ready), 0);
      chk("wait_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("wait_timeout", 32'(bus.timeout_err), 0);
      if (matching)
        break;
    end

    if (mode == 3) begin
      @(negedge clk);
      rst             = 1'b0;
      bus.req_valid   = '0;
      bus.s_rsp_valid = 1'b1;
      bus.s_rsp_id    = gid;
      bus.s_rsp_data  = $urandom;
      #1;
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_s_valid", 32'(bus.s_valid), 0);
      chk("rst_s_data", bus.s_data, 0);
      chk("rst_s_id", 32'(bus.s_id), 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_timeout", 32'(bus.timeout_err), 0);
      @(negedge clk);
      bus.s_rsp_valid = 1'b0;
      #1;
      chk("late_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("late_rsp_data", bus.rsp_data, 0);
      chk("late_busy", 32'(bus.busy), 0);
      exp_ptr = 0;
    end else begin
      @(negedge clk);
      bus.req_valid   = '0;
      bus.s_rsp_valid = 1'b0;
      #1;
      if (mode == 1) begin
        chk("tmo_pulse", 32'(bus.timeout_err), 1);
        chk("tmo_no_rsp", 32'(bus.rsp_valid), 0);
      end else begin
        chk("rsp_valid", 32'(bus.rsp_valid), 1 << g);
        chk("rsp_data", bus.rsp_data, rsp_exp);
        chk("rsp_no_tmo", 32'(bus.timeout_err), 0);
      end
      chk("done_busy", 32'(bus.busy), 0);
      @(negedge clk);
      #1;
      chk("pulse_rsp_end", 32'(bus.rsp_valid), 0);
      chk("pulse_tmo_end", 32'(bus.timeout_err), 0);
    end
  endtask

  initial begin
    int r;
    bus.req_valid   = '1;
    bus.req_data    = rand_payload();
    bus.s_ready     = 1'b1;
    bus.s_rsp_valid = 1'b0;
    bus.s_rsp_id    = '0;
    bus.s_rsp_data  = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", 32'(bus.req_ready), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_s_valid", 32'(bus.s_valid), 0);
    chk("reset_s_data", bus.s_data, 0);
    chk("reset_s_id", 32'(bus.s_id), 0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    chk("reset_timeout", 32'(bus.timeout_err), 0);
    @(negedge clk);
    bus.req_valid = '0;
    rst           = 1'b0;

    for (int i = 0; i < 5; i++)
      txn(4'b1111, 0, 1, 0, 1'b0);
    txn(4'b0010, 0, 1, 0, 1'b0);
    txn(4'b1000, 5, 3, 0, 1'b1);
    txn(4'b0100, 0, 0, 1, 1'b1);
    txn(4'b0001, 1, 0, 2, 1'b1);
    txn(4'b0010, 0, 0, 3, 1'b0);
    txn(4'b1111, 0, 1, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      txn(NREQ'($urandom_range(1, 15)), int'($urandom_range(0, 3)), int'($urandom_range(1, TMO)),
          (r < 6) ? 0 : (r < 8) ? 1 : 2, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub1_arb.md
SUB1_ARB -- requirements
Module: sub1_arb

Interface
REQ-001 Parameters (name, default, meaning); ports (name, direction, width, meaning) follow.
REQ-002 NREQ, 4, number of requesters sharing one sub1 instance; legal range 2..8.
REQ-003 DW, 32, request/response data width.
REQ-004 TIMEOUT, 255, max cycles waiting for a sub1 response.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 req_valid  in  NREQ  per-requester request valid.
REQ-009 req_ready  out  NREQ  per-requester accept; one-hot or zero.
REQ-010 req_data  in  NREQ x DW  packed per-requester payload.
REQ-011 rsp_valid  out  NREQ  one-cycle response pulse to the owning requester.
REQ-012 rsp_data  out  DW  response payload, shared by all requesters.
REQ-013 s_valid / s_ready  out / in  1 / 1  request handshake to sub1.
REQ-014 s_data / s_id  out / out  DW / IDW  payload and requester tag; IDW = clog2(NREQ).
REQ-015 s_rsp_valid / s_rsp_id / s_rsp_data  in  1 / IDW / DW  sub1 response.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 timeout_err  out  1  one-cycle pulse when a response times out.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE and WAIT_RSP; at most one transaction is outstanding.
REQ-019 IDLE: grant goes to the first asserted req_valid scanning from rr_ptr upward modulo NREQ; req_ready[grant] is combinationally high in that cycle; req_data is captured and the FSM moves to ISSUE.
REQ-020 On every acceptance, rr_ptr SHALL become (grant+1) mod NREQ, wrapping from NREQ-1 to 0.
REQ-021 ISSUE: s_valid=1 with captured s_data and s_id=grant; s_data and s_id are held stable until s_ready; the s_valid&&s_ready cycle moves the FSM to WAIT_RSP and clears the timeout counter.
REQ-022 Latency: s_valid is asserted the cycle after req_valid&&req_ready; minimum request-to-rsp_valid latency is 3 cycles.
REQ-023 WAIT_RSP: on s_rsp_valid with s_rsp_id==grant, register s_rsp_data to rsp_data, pulse rsp_valid[grant] for exactly one cycle, and go to IDLE.
REQ-024 A response with a mismatched id SHALL be ignored and SHALL NOT reset the timeout counter.
REQ-025 The timeout counter SHALL increment each WAIT_RSP cycle; when it reaches TIMEOUT, timeout_err pulses, no rsp_valid is generated, and the FSM goes to IDLE.
REQ-026 If a matching response and the timeout occur in the same cycle, the response wins and timeout_err stays low.
REQ-027 req_ready SHALL be zero in ISSUE and WAIT_RSP; a requester holding req_valid waits, and is not starved because of round robin (worst-case wait is NREQ-1 grants).
REQ-028 req_valid deasserting while ungranted is legal; no state changes.

Reset
REQ-029 While rst=1 on a clock edge: state=IDLE, rr_ptr=0, counter=0; req_ready, rsp_valid, s_valid, busy and timeout_err are 0; rsp_data, s_data and s_id are 0.
REQ-030 Reset asserted mid-transaction SHALL abandon it; a late sub1 response after reset is ignored because the FSM is in IDLE.

Structure
REQ-031 Package sub1_pkg SHALL hold arb_state_t (the FSM enum), req_id_t (IDW-bit tag) and the default parameter constants.
REQ-032 The round-robin grant logic SHALL be a separate sub-module rr_pick (inputs: req vector and ptr; outputs: grant index and any_req), instantiated once.

Verification
REQ-033 Single request: with NREQ=4, req_valid=0010 and s_ready=1, a response with id=1 returning 1 cycle after s_valid -> rsp_valid=0010 at cycle 3 with data matched.
REQ-034 Fairness: req_valid=1111 held continuously with immediate responses -> grant order 0,1,2,3,0 and rr_ptr wraps 3->0.
REQ-035 Backpressure: s_ready low for 5 cycles -> s_valid, s_data and s_id stable; all req_ready=0; busy=1.
REQ-036 Timeout: TIMEOUT=8 and no response -> timeout_err pulses exactly 8 cycles after entering WAIT_RSP, no rsp_valid, back to IDLE; a wrong-id response mid-wait is ignored.
REQ-037 Collision: a matching response on the TIMEOUT cycle -> rsp_valid pulses and timeout_err=0.
REQ-038 Reset mid-WAIT_RSP, then a late response -> all outputs 0, no rsp_valid, and the next request is granted from rr_ptr=0.
